// File: rtl/alu_issue.sv
// alu_issue: operand-fetch / issue stage feeding alu_unit; owns the register file and RAW scoreboard.
// Optional writeback-to-operand bypass is enabled by defining ALU_ISSUE_FWD_EN.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef ADD
`define ADD  5'd0
`define SUB  5'd1
`define AND  5'd2
`define OR   5'd3
`define XOR  5'd4
`define SHL  5'd5
`define SHR  5'd6
`define MOV  5'd7
`define MOVH 5'd8
`define CMP  5'd9
`endif

module alu_issue #(
  parameter int NUM_REGS = 16,
  parameter int RAW      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [2:0]        in_cc,
  input  logic [RAW-1:0]    in_rd,
  input  logic [RAW-1:0]    in_ra,
  input  logic [RAW-1:0]    in_rb,
  input  logic              in_use_imm,
  input  logic [15:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        opcode,
  output logic [2:0]        cc,
  output logic [`WIDTH-1:0] a_data,
  output logic [`WIDTH-1:0] b_data,
  output logic [RAW-1:0]    out_rd,
  input  logic              wb_en,
  input  logic [RAW-1:0]    wb_rd,
  input  logic [`WIDTH-1:0] wb_data
);
  localparam int W = `WIDTH;

  function automatic logic [W-1:0] sext_imm(input logic signed [15:0] imm);
    sext_imm = W'(imm);
  endfunction

  logic [W-1:0]        regfile_q [NUM_REGS];
  logic [W-1:0]        regfile_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic [4:0]          opcode_q, opcode_d;
  logic [2:0]          cc_q, cc_d;
  logic [W-1:0]        a_data_q, a_data_d;
  logic [W-1:0]        b_data_q, b_data_d;
  logic [RAW-1:0]      out_rd_q, out_rd_d;

  logic                fwd_a, fwd_b;
  logic                imm_on_a, imm_on_b, use_rb;
  logic                busy_a, busy_b, hazard, accept;
  logic [W-1:0]        rd_a, rd_b, imm_ext;
  logic [NUM_REGS-1:0] clr_mask, set_mask;

`ifdef ALU_ISSUE_FWD_EN
  assign fwd_a = wb_en && (wb_rd == in_ra) && (in_ra != '0);
  assign fwd_b = wb_en && (wb_rd == in_rb) && (in_rb != '0);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // Operand read: r0 is hardwired zero, bypass (if built) beats the array.
  assign rd_a = (in_ra == '0) ? '0 : (fwd_a ? wb_data : regfile_q[in_ra]);
  assign rd_b = (in_rb == '0) ? '0 : (fwd_b ? wb_data : regfile_q[in_rb]);

  assign imm_ext  = sext_imm(in_imm);
  assign imm_on_a = in_use_imm && ((in_opcode == `MOV) || (in_opcode == `MOVH));
  assign imm_on_b = in_use_imm && !imm_on_a;
  assign use_rb   = !imm_on_b;

  // A source being written back this cycle is not a hazard when it is bypassed.
  assign busy_a = busy_q[in_ra] && !fwd_a;
  assign busy_b = busy_q[in_rb] && !fwd_b;
  assign hazard = busy_a || (use_rb && busy_b) || busy_q[in_rd];

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wb_en && (wb_rd != '0)) clr_mask[wb_rd] = 1'b1;
    if (accept && (in_rd != '0)) set_mask[in_rd] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    cc_d        = cc_q;
    a_data_d    = a_data_q;
    b_data_d    = b_data_q;
    out_rd_d    = out_rd_q;
    if (accept) begin
      out_valid_d = 1'b1;
      opcode_d    = in_opcode;
      cc_d        = in_cc;
      a_data_d    = imm_on_a ? imm_ext : rd_a;
      b_data_d    = imm_on_b ? imm_ext : rd_b;
      out_rd_d    = in_rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // Set after clear so an issue and a writeback to the same register leave it busy.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    regfile_d = regfile_q;
    if (wb_en && (wb_rd != '0)) regfile_d[wb_rd] = wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      cc_q        <= '0;
      a_data_q    <= '0;
      b_data_q    <= '0;
      out_rd_q    <= '0;
      busy_q      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regfile_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      cc_q        <= cc_d;
      a_data_q    <= a_data_d;
      b_data_q    <= b_data_d;
      out_rd_q    <= out_rd_d;
      busy_q      <= busy_d;
      for (int i = 0; i < NUM_REGS; i++) regfile_q[i] <= regfile_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign opcode    = opcode_q;
  assign cc        = cc_q;
  assign a_data    = a_data_q;
  assign b_data    = b_data_q;
  assign out_rd    = out_rd_q;

endmodule
